// File: rtl/mux_scan_sequencer.sv
// Purpose : steps an external 8:1 mux through every input, samples its output and packs the samples into one word.
// Latency : dataValid rises N*(SETTLE+1) edges after the edge that accepts start.
// Backpressure: the finished word is held with dataValid high until dataReady; start is ignored while busy.
//
// Ports:
//   clk          - single clock, rising edge
//   reset        - asynchronous, active-high; clears all state
//   start        - request one full scan (only honoured when idle)
//   selectLine   - select driven to the mux
//   muxOut       - mux data output (same clock domain, combinational path)
//   busy         - high from accepted start until the output handshake completes
//   capturedData - assembled word, bit k sampled while selectLine == k
//   dataValid    - capturedData is complete and stable
//   dataReady    - downstream accepts capturedData when high together with dataValid
module mux_scan_sequencer #(
    parameter int SEL_WIDTH = 3,
    parameter int SETTLE    = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic [SEL_WIDTH-1:0]        selectLine,
    input  logic                        muxOut,
    output logic                        busy,
    output logic [(1<<SEL_WIDTH)-1:0]   capturedData,
    output logic                        dataValid,
    input  logic                        dataReady
);

    localparam int N = 1 << SEL_WIDTH;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Settle counter is sized for the largest legal SETTLE (15).
    localparam logic [3:0]           CNT_LAST = 4'(SETTLE - 1);
    localparam logic [SEL_WIDTH-1:0] SEL_LAST = {SEL_WIDTH{1'b1}};

    logic [1:0]           r_state;
    logic [3:0]           r_cnt;
    logic [SEL_WIDTH-1:0] r_sel;
    logic [N-1:0]         r_cap;
    logic                 r_busy;
    logic                 r_vld;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_sel   <= '0;
            r_cap   <= '0;
            r_busy  <= 1'b0;
            r_vld   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_sel <= '0;
                    if (start) begin
                        r_cap   <= '0;
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    // selectLine has been stable for SETTLE cycles once the
                    // counter reaches its last value; the next cycle samples.
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    r_cap[r_sel] <= muxOut;
                    if (r_sel == SEL_LAST) begin
                        // Scan terminates here; selectLine never wraps.
                        r_vld   <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_sel   <= r_sel + 1'b1;
                        r_cnt   <= 4'd0;
                        r_state <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    // Word and select are held until the consumer takes it.
                    if (dataReady) begin
                        r_vld   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_sel   <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign selectLine   = r_sel;
    assign capturedData = r_cap;
    assign busy         = r_busy;
    assign dataValid    = r_vld;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    // default instance (SETTLE = 1)
    logic       start = 1'b0;
    logic [2:0] sel;
    logic       mux_out;
    logic       busy;
    logic [7:0] cap;
    logic       vld;
    logic       rdy = 1'b1;
    logic [7:0] data_in = 8'h00;

    // slow instance (SETTLE = 3)
    logic       start2 = 1'b0;
    logic [2:0] sel2;
    logic       mux_out2;
    logic       busy2;
    logic [7:0] cap2;
    logic       vld2;
    logic       rdy2 = 1'b1;
    logic [7:0] data_in2 = 8'h81;

    assign mux_out  = data_in[sel];
    assign mux_out2 = data_in2[sel2];

    mux_scan_sequencer #(.SEL_WIDTH(3), .SETTLE(1)) dut (
        .clk(clk), .reset(reset), .start(start), .selectLine(sel), .muxOut(mux_out),
        .busy(busy), .capturedData(cap), .dataValid(vld), .dataReady(rdy)
    );

    mux_scan_sequencer #(.SEL_WIDTH(3), .SETTLE(3)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .selectLine(sel2), .muxOut(mux_out2),
        .busy(busy2), .capturedData(cap2), .dataValid(vld2), .dataReady(rdy2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // expected word and start-edge cycle per completed scan
    logic [7:0] exp_dat_q[$];
    int         exp_cyc_q[$];
    logic [7:0] exp_dat2_q[$];
    int         exp_cyc2_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitors ----------------
    bit seen = 0, chk_busy = 0;
    int rise_cyc = 0;
    always begin
        @(negedge clk); #1;
        if (chk_busy) begin
            chk_busy = 0;
            check("busy_after_handshake", {31'd0, busy}, 32'd0);
            check("valid_after_handshake", {31'd0, vld}, 32'd0);
        end
        if (!busy) seen = 0;
        if (vld && !seen) begin
            seen = 1;
            rise_cyc = cyc;
        end
        if (vld && rdy) begin
            if (exp_dat_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                automatic logic [7:0] ed = exp_dat_q.pop_front();
                automatic int         ec = exp_cyc_q.pop_front();
                check("captured_data", {24'd0, cap}, {24'd0, ed});
                check("valid_latency", rise_cyc - ec, 32'd16);
            end
            chk_busy = 1;
        end
    end

    bit seen2 = 0;
    int rise_cyc2 = 0;
    always begin
        @(negedge clk); #1;
        if (!busy2) seen2 = 0;
        if (vld2 && !seen2) begin
            seen2 = 1;
            rise_cyc2 = cyc;
        end
        if (vld2 && rdy2) begin
            if (exp_dat2_q.size() == 0) begin
                check("unexpected_valid2", 32'd1, 32'd0);
            end else begin
                automatic logic [7:0] ed = exp_dat2_q.pop_front();
                automatic int         ec = exp_cyc2_q.pop_front();
                check("captured_data2", {24'd0, cap2}, {24'd0, ed});
                check("valid_latency2", rise_cyc2 - ec, 32'd32);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Raise start at a negedge; it is accepted on the next rising edge.
    task automatic do_start(input bit expect_done, input logic [7:0] exp_word);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        if (expect_done) begin
            exp_dat_q.push_back(exp_word);
            exp_cyc_q.push_back(cyc);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || vld) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        // reset state
        #12;
        check("rst_sel", {29'd0, sel}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, vld}, 32'd0);
        check("rst_cap", {24'd0, cap}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1: basic scan, dataReady held high
        data_in = 8'hA5;
        rdy = 1'b1;
        do_start(1'b1, 8'hA5);
        check("busy_during_scan", {31'd0, busy}, 32'd1);
        wait_idle("scan_a5");
        repeat (3) @(negedge clk);

        // 2: consumer stalls for 5 cycles
        rdy = 1'b0;
        do_start(1'b1, 8'hA5);
        begin
            int n;
            n = 0;
            while (!vld && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (n >= 40) check("stall_wait_timeout", 32'd1, 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {31'd0, vld}, 32'd1);
            check("stall_cap", {24'd0, cap}, 32'hA5);
            check("stall_sel", {29'd0, sel}, 32'd7);
            @(negedge clk);
        end
        rdy = 1'b1;
        wait_idle("stall");
        repeat (3) @(negedge clk);

        // 3: start re-pulsed during an active scan is ignored
        data_in = 8'h3C;
        do_start(1'b1, 8'h3C);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("ignore_start");
        repeat (6) @(negedge clk);
        check("no_second_scan", {31'd0, busy}, 32'd0);

        // 4: reset in the middle of a scan
        data_in = 8'h5A;
        do_start(1'b0, 8'h00);
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_sel", {29'd0, sel}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_valid", {31'd0, vld}, 32'd0);
        check("midrst_cap", {24'd0, cap}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        data_in = 8'hFF;
        do_start(1'b1, 8'hFF);
        wait_idle("after_reset");
        repeat (3) @(negedge clk);

        // 5: SETTLE = 3 instance, each select held for 4 cycles
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk); #1;
        exp_dat2_q.push_back(8'h81);
        exp_cyc2_q.push_back(cyc);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            start2 = 1'b0;
            check("slow_sel_hold", {29'd0, sel2}, i / 4);
        end
        begin
            int n;
            n = 0;
            while ((busy2 || vld2) && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (n >= 40) check("slow_timeout", 32'd1, 32'd0);
        end

        // 6: input changes while select 4 is settling
        data_in = 8'h00;
        do_start(1'b1, 8'hF0);
        begin
            int n;
            n = 0;
            while (sel != 3'd4 && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (n >= 40) check("sel4_timeout", 32'd1, 32'd0);
        end
        data_in = 8'hFF;
        wait_idle("midscan_change");
        repeat (4) @(negedge clk);

        check("queue_drained", exp_dat_q.size(), 32'd0);
        check("queue2_drained", exp_dat2_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
